seg_scroll_scanner: RTL and testbench

SEG_SCROLL_SCANNER -- requirements
Module: seg_scroll_scanner

---
 rtl/seg_scroll_scanner.sv | 156 +++++++++++++++
 tb/tb_seg_scroll_scanner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_scanner.sv
// Scrolling four-digit seven-segment scanner: fetches four consecutive message entries, then commits them to the digits together.
// Optional build macro SEG_SCROLL_ACTIVE_LOW_EN selects inverted (active-low) digit drive with blank 7'h7F.
module seg_scroll_scanner #(
  parameter int STEP_CYCLES = 25000000
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       EN,
  input  logic       START,
  input  logic [3:0] LAST_ADDR,
  output logic       RA3,
  output logic       RA2,
  output logic       RA1,
  output logic       RA0,
  input  logic [6:0] DATA,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       BUSY,
  output logic       WRAP
);

  localparam int PW = $clog2(STEP_CYCLES);
  localparam logic [PW-1:0] PRE_MAX = PW'(STEP_CYCLES - 1);

`ifdef SEG_SCROLL_ACTIVE_LOW_EN
  localparam logic [6:0] BLANK = 7'h7F;
`else
  localparam logic [6:0] BLANK = 7'h00;
`endif

  typedef enum logic [1:0] {FETCH, COMMIT, WAIT} state_t;

  function automatic logic [6:0] drive_code(input logic [6:0] code);
`ifdef SEG_SCROLL_ACTIVE_LOW_EN
    return ~code;
`else
    return code;
`endif
  endfunction

  // Digit address wraps modulo the message length, so short messages repeat.
  function automatic logic [3:0] wrap_addr(input logic [3:0] b, input logic [1:0] i,
                                           input logic [3:0] last);
    logic [4:0] sum;
    logic [4:0] len;
    logic [4:0] rem;
    sum = {1'b0, b} + {3'b000, i};
    len = {1'b0, last} + 5'd1;
    rem = sum % len;
    return rem[3:0];
  endfunction

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [3:0]    base, base_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic          wrap_q, wrap_nxt;
  logic          capture, commit;
  logic [3:0]    ra;
  logic [6:0]    shadow [4];
  logic [6:0]    hex3_q, hex2_q, hex1_q, hex0_q;

  assign tick = (presc == PRE_MAX);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    base_nxt  = base;
    wrap_nxt  = 1'b0;
    capture   = 1'b0;
    commit    = 1'b0;
    if (START) begin
      state_nxt = FETCH;
      idx_nxt   = 2'd0;
      base_nxt  = 4'd0;
    end else begin
      case (state)
        FETCH: begin
          capture = 1'b1;
          idx_nxt = idx + 2'd1;
          if (idx == 2'd3) state_nxt = COMMIT;
        end
        COMMIT: begin
          commit    = 1'b1;
          state_nxt = WAIT;
        end
        WAIT: begin
          if (tick) begin
            if (EN) begin
              if (base >= LAST_ADDR) begin
                base_nxt = 4'd0;
                wrap_nxt = (base == LAST_ADDR);
              end else begin
                base_nxt = base + 4'd1;
              end
            end
            state_nxt = FETCH;
            idx_nxt   = 2'd0;
          end
        end
        default: begin
          state_nxt = FETCH;
          idx_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state  <= FETCH;
      idx    <= 2'd0;
      base   <= 4'd0;
      presc  <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      base   <= base_nxt;
      presc  <= tick ? '0 : presc + 1'b1;
      wrap_q <= wrap_nxt;
    end
  end

  // Shadow collects a full frame so the visible digits never show a mix of old and new entries.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < 4; i++) shadow[i] <= BLANK;
      hex3_q <= BLANK;
      hex2_q <= BLANK;
      hex1_q <= BLANK;
      hex0_q <= BLANK;
    end else begin
      if (capture) shadow[idx] <= DATA;
      if (commit) begin
        hex3_q <= drive_code(shadow[0]);
        hex2_q <= drive_code(shadow[1]);
        hex1_q <= drive_code(shadow[2]);
        hex0_q <= drive_code(shadow[3]);
      end
    end
  end

  assign ra = (state == FETCH) ? wrap_addr(base, idx, LAST_ADDR) : base;
  assign {RA3, RA2, RA1, RA0} = ra;
  assign HEX3 = hex3_q;
  assign HEX2 = hex2_q;
  assign HEX1 = hex1_q;
  assign HEX0 = hex0_q;
  assign BUSY = (state != WAIT);
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_seg_scroll_scanner.sv
// Scoreboard bench for seg_scroll_scanner: stimulus queues expected digit frames, a monitor checks each committed frame.
module tb_seg_scroll_scanner;

  logic       CLK = 1'b0;
  logic       CLR, EN, START;
  logic [3:0] LAST_ADDR;
  logic       RA3, RA2, RA1, RA0;
  logic [6:0] DATA;
  logic [6:0] HEX3, HEX2, HEX1, HEX0;
  logic       BUSY, WRAP;

  logic [3:0]  ra;
  logic [27:0] hex_all;
  logic [27:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;
  int cnt = 0;
  logic busy_prev = 1'b1;

`ifdef SEG_SCROLL_ACTIVE_LOW_EN
  localparam logic [6:0] BLANK = 7'h7F;
`else
  localparam logic [6:0] BLANK = 7'h00;
`endif

  seg_scroll_scanner #(.STEP_CYCLES(8)) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .START(START), .LAST_ADDR(LAST_ADDR),
    .RA3(RA3), .RA2(RA2), .RA1(RA1), .RA0(RA0), .DATA(DATA),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
    .BUSY(BUSY), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  // Register file model: entry n holds n+1.
  assign ra      = {RA3, RA2, RA1, RA0};
  assign DATA    = {3'b000, ra} + 7'd1;
  assign hex_all = {HEX3, HEX2, HEX1, HEX0};

  function automatic logic [6:0] enc(input int v);
    logic [6:0] c;
    c = 7'(v);
`ifdef SEG_SCROLL_ACTIVE_LOW_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  function automatic logic [27:0] frame(input int a, input int b, input int c, input int d);
    return {enc(a), enc(b), enc(c), enc(d)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_frames(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check("frames_drained", exp_q.size(), 0);
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && BUSY !== 1'b1; i++) step();
    check("busy_rise", BUSY, 1);
  endtask

  // Mirror of the free-running prescaler phase, used only to time stimulus.
  initial forever begin
    @(posedge CLK);
    cnt = CLR ? 0 : cnt + 1;
  end

  initial forever begin
    @(negedge CLK);
    if (CLR) begin
      busy_prev = 1'b1;
    end else begin
      if (busy_prev && BUSY === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %0h expected none", hex_all);
        end else begin
          check("frame", hex_all, exp_q.pop_front());
        end
      end
      busy_prev = BUSY;
      if (WRAP === 1'b1) wrap_cnt++;
    end
  end

  initial begin
    CLR = 1'b1; EN = 1'b0; START = 1'b0; LAST_ADDR = 4'd15;
    repeat (3) step();
    check("reset_hex", hex_all, {4{BLANK}});
    check("reset_ra", ra, 0);
    check("reset_wrap", WRAP, 0);
    check("reset_busy", BUSY, 1);

    // Reset release: first fetch walks addresses 0..3.
    exp_q.push_back(frame(1, 2, 3, 4));
    CLR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ra_first_fetch", ra, i);
      step();
    end
    check("busy_commit", BUSY, 1);
    step();
    check("busy_fall", BUSY, 0);
    check("hex_first", hex_all, frame(1, 2, 3, 4));

    // Scroll over three ticks.
    EN = 1'b1;
    exp_q.push_back(frame(2, 3, 4, 5));
    exp_q.push_back(frame(3, 4, 5, 6));
    exp_q.push_back(frame(4, 5, 6, 7));
    wait_frames(60);
    check("ra_wait_base3", ra, 3);
    check("no_wrap_yet", wrap_cnt, 0);

    // Short message: base 4 then 5, then wrap to 0.
    LAST_ADDR = 4'd5;
    exp_q.push_back(frame(5, 6, 1, 2));
    exp_q.push_back(frame(6, 1, 2, 3));
    wait_frames(40);
    exp_q.push_back(frame(1, 2, 3, 4));
    wait_busy(20);
    check("wrap_pulse", WRAP, 1);
    check("ra_after_wrap", ra, 0);
    step();
    check("wrap_one_cycle", WRAP, 0);
    wait_frames(20);
    check("wrap_count", wrap_cnt, 1);

    // START during FETCH idx 2 aborts the refresh.
    LAST_ADDR = 4'd15;
    exp_q.push_back(frame(2, 3, 4, 5));
    wait_frames(20);
    EN = 1'b0;
    exp_q.push_back(frame(1, 2, 3, 4));
    wait_busy(20);
    check("ra_refresh_idx0", ra, 1);
    step();
    step();
    check("ra_refresh_idx2", ra, 3);
    START = 1'b1;
    step();
    START = 1'b0;
    check("ra_after_start", ra, 0);
    check("hex_held_after_start", hex_all, frame(2, 3, 4, 5));
    check("busy_after_start", BUSY, 1);
    wait_frames(30);

    // START coinciding with a tick while EN=1.
    EN = 1'b1;
    exp_q.push_back(frame(2, 3, 4, 5));
    wait_frames(20);
    for (int i = 0; i < 10 && (cnt % 8) != 7; i++) step();
    check("in_wait_at_tick", BUSY, 0);
    exp_q.push_back(frame(1, 2, 3, 4));
    START = 1'b1;
    step();
    START = 1'b0;
    EN = 1'b0;
    check("ra_start_tick", ra, 0);
    check("no_wrap_start", WRAP, 0);
    wait_frames(20);

    // Single-entry message repeats entry 0 across all digits.
    LAST_ADDR = 4'd0;
    exp_q.push_back(frame(1, 1, 1, 1));
    wait_frames(20);
    check("wrap_count_final", wrap_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
